sb_arbiter: RTL and testbench
=============================

SB_ARBITER -- requirements
Module: sb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, means the maximum number of cycles strobe stays high awaiting sback before the transfer is abandoned (legal range 1..255).
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 reqA/reqB  input  1 each  transfer request from requester A (mailbox engine) / B (Z80 port); held high until ack.
REQ-005 rwA/rwB  input  1 each  1 = write, 0 = read.
REQ-006 adrA/adrB, datiA/datiB  input  8 each  system-bus address and write data; stable while req is high.
REQ-007 ackA/ackB  output  1 each  single-cycle completion pulse.
REQ-008 errA/errB  output  1 each  valid with ack; 1 = transfer timed out.
REQ-009 datoA/datoB  output  8 each  read data; valid with ack and held until that requester's next ack.
REQ-010 sbstb, sbrw  output  1 each  system-bus strobe and direction to the SB_SPI hard block.
REQ-011 sbadr, sbdati  output  8 each  system-bus address and write data.
REQ-012 sbdato  input  8  system-bus read data.
REQ-013 sback  input  1  system-bus acknowledge.
REQ-014 busy  output  1  high while sbstb is high.

Function
REQ-015 The FSM shall have exactly two states: IDLE (sbstb = 0) and XFER (sbstb = 1).
REQ-016 In IDLE with at least one req high at edge N, the arbiter shall grant, latch the winner's rw/adr/dati onto sbrw/sbadr/sbdati, and drive sbstb = 1 from N+1.
REQ-017 Arbitration shall be round-robin: if both requests are high, the requester not granted last wins; after reset, A has priority.
REQ-018 sbrw, sbadr and sbdati shall stay constant for the whole of XFER.
REQ-019 In XFER, when sback = 1 is sampled at edge M, the arbiter shall:
- drive sbstb = 0 from M+1;
- pulse the winner's ack for the single cycle M+1 with err = 0;
- on reads, load the winner's dato with sbdato sampled at M.
REQ-020 On writes, the winner's dato shall be unchanged.
REQ-021 A timeout counter shall clear on entry to XFER and increment each XFER cycle without sback.
REQ-022 If the counter reaches TIMEOUT with sback still 0, sbstb shall drop the next cycle and the winner's ack and err shall both pulse in that same cycle.
REQ-023 On timeout, dato shall be unchanged, and the FSM shall return to IDLE.
REQ-024 sback and timeout in the same cycle: sback takes precedence (err = 0).
REQ-025 After every XFER, sbstb shall stay low for at least one cycle (IDLE) before the next grant.
REQ-026 A back-to-back transfer shall therefore have at least 1 low-strobe cycle between strobes.
REQ-027 A req still high in the ack cycle shall be treated as a new request, arbitrated in IDLE the following cycle.
REQ-028 A req dropped while its transfer is in XFER shall not abort the transfer; the ack is still issued.
REQ-029 Only the granted requester's ack, err and dato shall change; the loser's req is ignored until IDLE.
REQ-030 sback seen in IDLE shall be ignored.
REQ-031 ackA and ackB shall never be high in the same cycle.

Reset
REQ-032 While rst_n = 0, the following shall be 0 asynchronously: sbstb, sbrw, sbadr, sbdati, ackA, ackB, errA, errB, datoA, datoB, busy, timeout counter, and the round-robin pointer (A preferred); the state shall be IDLE.
REQ-033 Reset asserted mid-XFER shall drop sbstb immediately with no ack issued.
REQ-034 After rst_n rises, the first grant shall not occur before the first clock edge with rst_n = 1.

Verification
REQ-035 Single read: reqB with rwB = 0, adrB = 0x0C; sback after 3 cycles with sbdato = 0x18 -> sbstb high 4 cycles, sbadr = 0x0C, ackB one cycle, datoB = 0x18, errB = 0.
REQ-036 Contention: reqA and reqB rise together after reset -> A served first, B served second with at least 1 low sbstb cycle between strobes; repeating the case after B's transfer, A then B.
REQ-037 Back-to-back: reqA held high for 3 write transfers, sback immediate -> 3 ackA pulses, sbstb pattern 1,0,1,0,1, and B (raised mid-sequence) interleaved after A's current transfer.
REQ-038 Timeout: TIMEOUT = 4, sback never asserted -> sbstb high exactly 4 cycles, ackA and errA pulse together, datoA unchanged, next request proceeds normally.
REQ-039 Reset mid-transfer: rst_n low during XFER -> sbstb = 0 immediately, no ack, all outputs 0; after release, a new reqB completes normally.
REQ-040 Stray sback: sback pulsed in IDLE -> no ack, no dato change.

Source files
------------

// File: rtl/sb_arbiter_if.sv
// sb_arbiter_if -- two requester ports (A: mailbox engine, B: Z80 port) plus
// the system-bus side towards the SB_SPI hard block.
//   master : arbiter view (requests/bus responses in, acks/bus strobe out)
//   slave  : environment view (requesters and bus target)
interface sb_arbiter_if;
  logic       reqA, reqB;
  logic       rwA, rwB;
  logic [7:0] adrA, adrB;
  logic [7:0] datiA, datiB;
  logic       ackA, ackB;
  logic       errA, errB;
  logic [7:0] datoA, datoB;
  logic       sbstb, sbrw;
  logic [7:0] sbadr, sbdati;
  logic [7:0] sbdato;
  logic       sback;
  logic       busy;

  modport master (
    input  reqA, reqB, rwA, rwB, adrA, adrB, datiA, datiB, sbdato, sback,
    output ackA, ackB, errA, errB, datoA, datoB, sbstb, sbrw, sbadr, sbdati, busy
  );

  modport slave (
    output reqA, reqB, rwA, rwB, adrA, adrB, datiA, datiB, sbdato, sback,
    input  ackA, ackB, errA, errB, datoA, datoB, sbstb, sbrw, sbadr, sbdati, busy
  );
endinterface

// File: rtl/sb_arbiter.sv
// sb_arbiter -- round-robin arbiter giving two requesters access to the
// 8-bit system bus, with a per-transfer sback timeout.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sb_arbiter_if.master (requester A/B handshakes + system bus)
// Parameter TIMEOUT (1..255): strobe cycles waited for sback before the
// transfer is abandoned with err = 1.
module sb_arbiter #(
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst_n,
  sb_arbiter_if.master bus
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  // Counter value in the last allowed strobe cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       start, grant_b, fin_ok, fin_tout;
  logic       owner_b;   // 1: current transfer belongs to B
  logic       prefer_b;  // round-robin pointer, 0 = A preferred
  logic [7:0] cnt;

  logic       sbrw_q;
  logic [7:0] sbadr_q, sbdati_q;
  logic       ack_a_q, ack_b_q, err_a_q, err_b_q;
  logic [7:0] dato_a_q, dato_b_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and transfer events
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    fin_ok    = 1'b0;
    fin_tout  = 1'b0;
    // B wins if it is alone or if both request and B is next in turn
    grant_b   = bus.reqB & (~bus.reqA | prefer_b);
    case (state)
      IDLE: begin
        // sback is deliberately not looked at here
        if (bus.reqA | bus.reqB) begin
          start     = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        // sback wins over a timeout in the same cycle
        if (bus.sback) begin
          fin_ok    = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          fin_tout  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus latch, timeout counter, requester responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_b  <= 1'b0;
      prefer_b <= 1'b0;
      cnt      <= '0;
      sbrw_q   <= 1'b0;
      sbadr_q  <= '0;
      sbdati_q <= '0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      err_a_q  <= 1'b0;
      err_b_q  <= 1'b0;
      dato_a_q <= '0;
      dato_b_q <= '0;
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      err_a_q <= 1'b0;
      err_b_q <= 1'b0;

      if (start) begin
        owner_b  <= grant_b;
        prefer_b <= ~grant_b;
        sbrw_q   <= grant_b ? bus.rwB   : bus.rwA;
        sbadr_q  <= grant_b ? bus.adrB  : bus.adrA;
        sbdati_q <= grant_b ? bus.datiB : bus.datiA;
        cnt      <= '0;
      end else if (state == XFER && !bus.sback) begin
        cnt <= cnt + 8'd1;
      end

      if (fin_ok || fin_tout) begin
        if (owner_b) begin
          ack_b_q <= 1'b1;
          err_b_q <= fin_tout;
          if (fin_ok && !sbrw_q) dato_b_q <= bus.sbdato;
        end else begin
          ack_a_q <= 1'b1;
          err_a_q <= fin_tout;
          if (fin_ok && !sbrw_q) dato_a_q <= bus.sbdato;
        end
      end
    end
  end

  // Strobe comes straight from the state flop so reset drops it at once.
  assign bus.sbstb  = (state == XFER);
  assign bus.busy   = (state == XFER);
  assign bus.sbrw   = sbrw_q;
  assign bus.sbadr  = sbadr_q;
  assign bus.sbdati = sbdati_q;
  assign bus.ackA   = ack_a_q;
  assign bus.ackB   = ack_b_q;
  assign bus.errA   = err_a_q;
  assign bus.errB   = err_b_q;
  assign bus.datoA  = dato_a_q;
  assign bus.datoB  = dato_b_q;

endmodule

// File: tb/tb_sb_arbiter.sv
// tb_sb_arbiter -- directed scoreboard bench for sb_arbiter (TIMEOUT = 4).
// Stimulus pushes expected strobes and acks; a negedge monitor pops and
// compares whenever the DUT raises sbstb or an ack.
module tb_sb_arbiter;

  typedef struct {
    logic       b;
    logic       err;
    logic [7:0] dato;
  } ack_exp_t;

  typedef struct {
    logic [7:0] adr;
    logic       rw;
    logic [7:0] dati;
    int         len;
  } stb_exp_t;

  logic clk, rst_n;
  sb_arbiter_if bus ();

  sb_arbiter #(.TIMEOUT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  ack_exp_t ack_q[$];
  stb_exp_t stb_q[$];

  // stimulus-owned controls
  int         issA = 0, issB = 0;
  int         rsp_delay = 0;
  logic [7:0] rsp_xor = 8'h5A;
  logic       stray = 1'b0;
  // requester-owned
  int         doneA = 0, doneB = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Requester A: holds req while it still owes transfers, drops in ack cycle.
  initial begin
    bus.reqA = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ackA) doneA++;
      bus.reqA = (issA != doneA);
    end
  end

  initial begin
    bus.reqB = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ackB) doneB++;
      bus.reqB = (issB != doneB);
    end
  end

  // Bus target: acks in strobe cycle rsp_delay (0-based); -1 never acks.
  initial begin
    int xc;
    xc = 0;
    bus.sback  = 1'b0;
    bus.sbdato = 8'h00;
    forever begin
      @(negedge clk);
      bus.sback  = 1'b0;
      bus.sbdato = 8'h00;
      if (stray) begin
        bus.sback  = 1'b1;
        bus.sbdato = 8'hEE;
      end else if (rst_n && bus.sbstb) begin
        if (rsp_delay >= 0 && xc == rsp_delay) begin
          bus.sback  = 1'b1;
          bus.sbdato = bus.sbadr ^ rsp_xor;
        end
        xc++;
      end else begin
        xc = 0;
      end
    end
  end

  // Monitor
  initial begin
    logic     in_s;
    int       len;
    stb_exp_t cur;
    ack_exp_t ae;
    in_s = 1'b0;
    len  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_s = 1'b0;
      end else begin
        if (bus.sbstb && !in_s) begin
          in_s = 1'b1;
          len  = 1;
          check("busy_with_stb", bus.busy, 1);
          if (stb_q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
            cur = '{adr: bus.sbadr, rw: bus.sbrw, dati: bus.sbdati, len: 0};
          end else begin
            cur = stb_q.pop_front();
            check("sbadr", bus.sbadr, cur.adr);
            check("sbrw", bus.sbrw, cur.rw);
            check("sbdati", bus.sbdati, cur.dati);
          end
        end else if (bus.sbstb && in_s) begin
          len++;
          check("sb_stable", {bus.sbrw, bus.sbadr, bus.sbdati}, {cur.rw, cur.adr, cur.dati});
        end else if (!bus.sbstb && in_s) begin
          in_s = 1'b0;
          check("strobe_len", len, cur.len);
        end

        if (bus.ackA && bus.ackB) check("ack_both", 1, 0);
        else if (bus.ackA || bus.ackB) begin
          if (ack_q.size() == 0) check("unexpected_ack", {bus.ackA, bus.ackB}, 0);
          else begin
            ae = ack_q.pop_front();
            check("ack_who", bus.ackB, ae.b);
            check("ack_err", ae.b ? bus.errB : bus.errA, ae.err);
            check("ack_dato", ae.b ? bus.datoB : bus.datoA, ae.dato);
          end
        end
      end
    end
  end

  task automatic push_stb(input logic [7:0] adr, input logic rw, input logic [7:0] dati, input int len);
    stb_q.push_back('{adr: adr, rw: rw, dati: dati, len: len});
  endtask

  task automatic push_ack(input logic b, input logic err, input logic [7:0] dato);
    ack_q.push_back('{b: b, err: err, dato: dato});
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!(issA == doneA && issB == doneB && !bus.sbstb) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, (n < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_strobe(input string name);
    int n;
    n = 0;
    while (!bus.sbstb && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_strobe_seen"}, bus.sbstb, 1);
  endtask

  initial begin
    bus.rwA = 1'b0; bus.rwB = 1'b0;
    bus.adrA = 8'h00; bus.adrB = 8'h00;
    bus.datiA = 8'h00; bus.datiB = 8'h00;
    rst_n = 1'b0;
    #3;
    check("reset_outputs",
          {bus.sbstb, bus.sbrw, bus.sbadr, bus.sbdati, bus.ackA, bus.ackB,
           bus.errA, bus.errB, bus.busy}, 0);
    check("reset_dato", {bus.datoA, bus.datoB}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single read on B, sback in 4th strobe cycle (also the timeout cycle)
    rsp_delay = 3; rsp_xor = 8'h14;
    bus.rwB = 1'b0; bus.adrB = 8'h0C; bus.datiB = 8'h77;
    push_stb(8'h0C, 1'b0, 8'h77, 4);
    push_ack(1'b1, 1'b0, 8'h18);
    issB++;
    wait_done("single_read", 40);
    check("datoB_held", bus.datoB, 8'h18);

    // Contention: A write then B read
    rsp_delay = 1; rsp_xor = 8'h5A;
    bus.rwA = 1'b1; bus.adrA = 8'h10; bus.datiA = 8'hAA;
    bus.rwB = 1'b0; bus.adrB = 8'h20; bus.datiB = 8'h00;
    push_stb(8'h10, 1'b1, 8'hAA, 2); push_ack(1'b0, 1'b0, 8'h00);
    push_stb(8'h20, 1'b0, 8'h00, 2); push_ack(1'b1, 1'b0, 8'h7A);
    @(posedge clk); #1;
    issA++; issB++;
    wait_done("contend1", 60);

    // Contention again: A read then B write
    bus.rwA = 1'b0; bus.adrA = 8'h11; bus.datiA = 8'h33;
    bus.rwB = 1'b1; bus.adrB = 8'h21; bus.datiB = 8'h55;
    push_stb(8'h11, 1'b0, 8'h33, 2); push_ack(1'b0, 1'b0, 8'h4B);
    push_stb(8'h21, 1'b1, 8'h55, 2); push_ack(1'b1, 1'b0, 8'h7A);
    @(posedge clk); #1;
    issA++; issB++;
    wait_done("contend2", 60);

    // Back-to-back A writes, B read raised during A's first transfer
    rsp_delay = 0;
    bus.rwA = 1'b1; bus.adrA = 8'h30; bus.datiA = 8'h01;
    bus.rwB = 1'b0; bus.adrB = 8'h40; bus.datiB = 8'h02;
    push_stb(8'h30, 1'b1, 8'h01, 1); push_ack(1'b0, 1'b0, 8'h4B);
    push_stb(8'h40, 1'b0, 8'h02, 1); push_ack(1'b1, 1'b0, 8'h1A);
    push_stb(8'h30, 1'b1, 8'h01, 1); push_ack(1'b0, 1'b0, 8'h4B);
    push_stb(8'h30, 1'b1, 8'h01, 1); push_ack(1'b0, 1'b0, 8'h4B);
    issA += 3;
    wait_strobe("b2b");
    issB++;
    wait_done("b2b", 80);

    // Timeout on A read, dato must stay
    rsp_delay = -1;
    bus.rwA = 1'b0; bus.adrA = 8'h50; bus.datiA = 8'h09;
    push_stb(8'h50, 1'b0, 8'h09, 4); push_ack(1'b0, 1'b1, 8'h4B);
    issA++;
    wait_done("timeout", 40);
    check("datoA_after_tout", bus.datoA, 8'h4B);

    // Next request proceeds normally
    rsp_delay = 2;
    bus.adrA = 8'h51;
    push_stb(8'h51, 1'b0, 8'h09, 3); push_ack(1'b0, 1'b0, 8'h0B);
    issA++;
    wait_done("post_tout", 40);

    // Stray sback in IDLE
    stray = 1'b1;
    @(negedge clk); @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_datoA", bus.datoA, 8'h0B);
    check("stray_datoB", bus.datoB, 8'h1A);
    check("stray_idle", {bus.sbstb, bus.ackA, bus.ackB}, 0);

    // Reset in the middle of a transfer
    rsp_delay = -1;
    bus.rwA = 1'b1; bus.adrA = 8'h60; bus.datiA = 8'hC3;
    push_stb(8'h60, 1'b1, 8'hC3, 0);
    issA++;
    wait_strobe("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b0;
    issA = doneA;
    #1;
    check("rst_mid_outputs",
          {bus.sbstb, bus.sbrw, bus.sbadr, bus.sbdati, bus.ackA, bus.ackB,
           bus.errA, bus.errB, bus.busy}, 0);
    check("rst_mid_dato", {bus.datoA, bus.datoB}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_no_strobe", bus.sbstb, 0);

    // New B read after release
    rsp_delay = 1;
    bus.rwB = 1'b0; bus.adrB = 8'h70; bus.datiB = 8'h00;
    push_stb(8'h70, 1'b0, 8'h00, 2); push_ack(1'b1, 1'b0, 8'h2A);
    issB++;
    wait_done("post_rst", 40);

    check("ack_queue_empty", ack_q.size(), 0);
    check("stb_queue_empty", stb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
